// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the dcache miss/writeback/flush sequencer: address fields,
// default geometry and the controller state encoding.
package dcache_ctrl_pkg;
  localparam int          DNSETS      = 8;
  localparam int          DIDX_W      = $clog2(DNSETS);
  localparam int          DTAG_W      = 32 - 3 - DIDX_W;
  localparam logic [31:0] DHITCNT_ADR = 32'h0000_3100;

  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } dcachef_t;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, FCHK, FWB0, FWB1, FCNT, DONE
  } dcctl_state_t;
endpackage

// File: rtl/dcache_ctrl.sv
// Miss/writeback/flush sequencer for the 2-way set-assoc dcache: victim writeback,
// 2-word fill, and a halt-time walk that writes back dirty blocks and the hit count.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int          NSETS       = 8,
  parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100,
  localparam int         IDX_W       = $clog2(NSETS),
  localparam int         TAG_W       = 32 - 3 - IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             halt,
  input  logic             dmemREN,
  input  logic             dmemWEN,
  input  logic [31:0]      dmemaddr,
  input  logic             lk_hit,
  input  logic             lk_lru,
  output logic [IDX_W-1:0] ctl_idx,
  output logic             ctl_way,
  output logic             ctl_blk,
  input  logic             ctl_valid,
  input  logic             ctl_dirty,
  input  logic [TAG_W-1:0] ctl_tag,
  input  logic [31:0]      ctl_rdata,
  output logic             fill_wen,
  output logic             clean_wen,
  output logic             dhit,
  output logic             flushed,
  output logic             dREN,
  output logic             dWEN,
  output logic [31:0]      daddr,
  output logic [31:0]      dstore,
  input  logic             dwait,
  input  logic [31:0]      dload
);
  dcctl_state_t     state_q, state_d;
  logic [31:0]      hitcnt_q, hitcnt_d;
  logic             retry_q, retry_d;
  logic [IDX_W:0]   ptr_q, ptr_d;     // {set, way}: way is the fast-moving bit
  logic             way_q, way_d;

  logic [IDX_W-1:0] idx_in;
  logic             req, ptr_last;
  logic             unused_boff;

  assign idx_in      = dmemaddr[3 +: IDX_W];
  assign req         = dmemREN | dmemWEN;
  assign ptr_last    = (ptr_q == {IDX_W'(NSETS - 1), 1'b1});
  assign unused_boff = ^dmemaddr[2:0];

  always_comb begin
    state_d   = state_q;
    hitcnt_d  = hitcnt_q;
    retry_d   = retry_q;
    ptr_d     = ptr_q;
    way_d     = way_q;
    ctl_idx   = idx_in;
    ctl_way   = way_q;
    ctl_blk   = 1'b0;
    fill_wen  = 1'b0;
    clean_wen = 1'b0;
    dhit      = 1'b0;
    flushed   = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    case (state_q)
      IDLE: begin
        ctl_way = lk_lru;
        dhit    = lk_hit & req & ~halt;
        if (halt) begin
          state_d = FCHK;
          ptr_d   = '0;
        end else if (dhit) begin
          // the re-lookup after a fill is the same access, so it is not counted
          if (!retry_q) hitcnt_d = hitcnt_q + 32'd1;
          retry_d = 1'b0;
        end else if (req) begin
          way_d   = lk_lru;
          state_d = (ctl_valid & ctl_dirty) ? WB0 : LD0;
        end
      end
      WB0, WB1: begin
        ctl_blk = (state_q == WB1);
        dWEN    = 1'b1;
        daddr   = {ctl_tag, idx_in, ctl_blk, 2'b00};
        dstore  = ctl_rdata;
        if (!dwait) begin
          if (state_q == WB0) state_d = WB1;
          else begin
            clean_wen = 1'b1;
            state_d   = halt ? IDLE : LD0;
          end
        end
      end
      LD0, LD1: begin
        ctl_blk = (state_q == LD1);
        dREN    = 1'b1;
        daddr   = {dmemaddr[31:3], ctl_blk, 2'b00};
        if (!dwait) begin
          fill_wen = 1'b1;
          if (state_q == LD0) state_d = LD1;
          else begin
            retry_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      FCHK: begin
        ctl_idx = ptr_q[IDX_W:1];
        ctl_way = ptr_q[0];
        if (ctl_valid & ctl_dirty) state_d = FWB0;
        else if (ptr_last)         state_d = FCNT;
        else                       ptr_d   = ptr_q + 1'b1;
      end
      FWB0, FWB1: begin
        ctl_idx = ptr_q[IDX_W:1];
        ctl_way = ptr_q[0];
        ctl_blk = (state_q == FWB1);
        dWEN    = 1'b1;
        daddr   = {ctl_tag, ptr_q[IDX_W:1], ctl_blk, 2'b00};
        dstore  = ctl_rdata;
        if (!dwait) begin
          if (state_q == FWB0) state_d = FWB1;
          else begin
            clean_wen = 1'b1;
            if (ptr_last) state_d = FCNT;
            else begin
              ptr_d   = ptr_q + 1'b1;
              state_d = FCHK;
            end
          end
        end
      end
      FCNT: begin
        dWEN   = 1'b1;
        daddr  = HITCNT_ADDR;
        dstore = hitcnt_q;
        if (!dwait) state_d = DONE;
      end
      DONE:    flushed = 1'b1;
      default: state_d = IDLE;
    endcase
    // a reset edge must never commit a half-finished transfer into the arrays
    if (RST) begin
      fill_wen  = 1'b0;
      clean_wen = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      hitcnt_q <= '0;
      retry_q  <= 1'b0;
      ptr_q    <= '0;
      way_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hitcnt_q <= hitcnt_d;
      retry_q  <= retry_d;
      ptr_q    <= ptr_d;
      way_q    <= way_d;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: behavioural tag/data arrays and a fixed-latency
// memory around the sequencer, a table of IDLE lookups plus miss/flush/reset sequences.
module tb_dcache_ctrl;
  import dcache_ctrl_pkg::*;
  localparam int NS = 8, IW = 3, TW = 26, WAITN = 3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST, halt, dmemREN, dmemWEN, lk_hit, lk_lru;
  logic [31:0]   dmemaddr;
  logic [IW-1:0] ctl_idx;
  logic          ctl_way, ctl_blk, ctl_valid, ctl_dirty;
  logic [TW-1:0] ctl_tag;
  logic [31:0]   ctl_rdata, daddr, dstore, dload;
  logic          fill_wen, clean_wen, dhit, flushed, dREN, dWEN, dwait;

  dcache_ctrl #(.NSETS(NS), .HITCNT_ADDR(32'h0000_3100)) dut (
    .CLK(CLK), .RST(RST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .lk_hit(lk_hit), .lk_lru(lk_lru), .ctl_idx(ctl_idx),
    .ctl_way(ctl_way), .ctl_blk(ctl_blk), .ctl_valid(ctl_valid), .ctl_dirty(ctl_dirty),
    .ctl_tag(ctl_tag), .ctl_rdata(ctl_rdata), .fill_wen(fill_wen), .clean_wen(clean_wen),
    .dhit(dhit), .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dwait(dwait), .dload(dload));

  // cache arrays
  logic          m_valid [NS][2];
  logic          m_dirty [NS][2];
  logic [TW-1:0] m_tag   [NS][2];
  logic [31:0]   m_data  [NS][2][2];
  logic          m_lru   [NS];
  dcachef_t      fa;
  assign fa        = dmemaddr;
  assign lk_hit    = (m_valid[fa.idx][0] && m_tag[fa.idx][0] == fa.tag) ||
                     (m_valid[fa.idx][1] && m_tag[fa.idx][1] == fa.tag);
  assign lk_lru    = m_lru[fa.idx];
  assign ctl_valid = m_valid[ctl_idx][ctl_way];
  assign ctl_dirty = m_dirty[ctl_idx][ctl_way];
  assign ctl_tag   = m_tag[ctl_idx][ctl_way];
  assign ctl_rdata = m_data[ctl_idx][ctl_way][ctl_blk];

  // memory: each transfer holds dwait for WAITN cycles unless hold_wait forces it
  int   wcnt = 0;
  logic hold_wait;
  assign dwait = (dREN | dWEN) & (hold_wait | (wcnt != WAITN));
  assign dload = daddr ^ 32'hA5A5_0000;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } xfer_t;
  xfer_t log_q[$];
  int n_chk = 0, n_fail = 0;
  int dhit_cnt = 0, fill_cnt = 0, clean_cnt = 0, both_cnt = 0;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // one clock: observe pre-edge outputs, then update arrays/memory after the edge
  task tick();
    logic f, c, bk, wy; logic [IW-1:0] ix; logic [31:0] ld; logic [TW-1:0] tg; int wn;
    #2;
    f = fill_wen; c = clean_wen; ix = ctl_idx; wy = ctl_way; bk = ctl_blk;
    ld = dload; tg = fa.tag;
    if (dhit && !RST) dhit_cnt++;
    if (dREN && dWEN) both_cnt++;
    if ((dREN || dWEN) && !dwait && !RST) log_q.push_back({dWEN, daddr, dWEN ? dstore : dload});
    if ((dREN || dWEN) && dwait) wn = (wcnt == WAITN) ? wcnt : wcnt + 1;
    else wn = 0;
    if (f) fill_cnt++;
    if (c) clean_cnt++;
    @(posedge CLK); #1;
    wcnt = wn;
    if (f) begin
      m_data[ix][wy][bk] = ld;
      if (bk) begin m_tag[ix][wy] = tg; m_valid[ix][wy] = 1'b1; m_dirty[ix][wy] = 1'b0; end
    end
    if (c) m_dirty[ix][wy] = 1'b0;
    @(negedge CLK);
  endtask

  task clear_model();
    for (int s = 0; s < NS; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_tag[s][w] = '0;
        m_data[s][w][0] = '0; m_data[s][w][1] = '0;
      end
    end
  endtask

  task preload(input int s, input int w, input logic v, input logic d,
               input logic [TW-1:0] t, input logic [31:0] d0, input logic [31:0] d1);
    m_valid[s][w] = v; m_dirty[s][w] = d; m_tag[s][w] = t;
    m_data[s][w][0] = d0; m_data[s][w][1] = d1;
  endtask

  function automatic logic [31:0] mkaddr(input logic [TW-1:0] t, input int s, input logic b);
    dcachef_t a;
    a.tag = t; a.idx = IW'(s); a.blkoff = b; a.bytoff = 2'b00;
    return a;
  endfunction

  task do_reset();
    RST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; hold_wait = 1'b0;
    dmemaddr = '0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task wait_flushed(input string nm, input int lim);
    int cyc;
    cyc = 0;
    #1;
    while (!flushed && cyc < lim) begin tick(); cyc++; #1; end
    chk({nm, " flushed"}, 65'(flushed), 65'(1));
  endtask

  typedef struct {
    logic ren, wen, hlt; logic [31:0] addr; logic exp_dhit;
  } vec_t;
  vec_t vt[8];

  initial begin
    int cyc, base, fb, cb, db, exp_hits;
    xfer_t ex[5];
    clear_model();
    do_reset();
    #1;
    chk("rst dREN", 65'(dREN), 65'(0));
    chk("rst dWEN", 65'(dWEN), 65'(0));
    chk("rst flushed", 65'(flushed), 65'(0));
    chk("rst dhit", 65'(dhit), 65'(0));
    chk("rst wen", 65'({fill_wen, clean_wen}), 65'(0));

    // IDLE lookup table
    preload(1, 0, 1, 0, 26'h0AB, 32'h1111_0000, 32'h1111_0001);
    preload(3, 1, 1, 0, 26'h123, 32'h3333_0000, 32'h3333_0001);
    vt[0] = '{1, 0, 0, mkaddr(26'h0AB, 1, 0), 1};
    vt[1] = '{0, 1, 0, mkaddr(26'h123, 3, 0), 1};
    vt[2] = '{1, 1, 0, mkaddr(26'h0AB, 1, 1), 1};
    vt[3] = '{0, 0, 0, mkaddr(26'h0AB, 1, 0), 0};
    vt[4] = '{1, 0, 0, mkaddr(26'h0CD, 1, 0), 0};
    vt[5] = '{1, 0, 1, mkaddr(26'h0AB, 1, 0), 0};
    vt[6] = '{0, 1, 0, mkaddr(26'h0AB, 5, 0), 0};
    vt[7] = '{1, 0, 0, mkaddr(26'h123, 3, 1), 1};
    exp_hits = 0;
    for (int i = 0; i < 8; i++) begin
      dmemREN = vt[i].ren; dmemWEN = vt[i].wen; halt = vt[i].hlt; dmemaddr = vt[i].addr;
      #1;
      chk($sformatf("vec%0d dhit", i), 65'(dhit), 65'(vt[i].exp_dhit));
      chk($sformatf("vec%0d memreq", i), 65'({dREN, dWEN}), 65'(0));
      if (!vt[i].exp_dhit) begin dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0; end
      if (vt[i].exp_dhit) exp_hits++;
      tick();
    end
    dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
    tick();

    // clean-victim miss in set 2
    base = log_q.size(); fb = fill_cnt;
    m_lru[2] = 1'b0;
    dmemREN = 1'b1; dmemaddr = mkaddr(26'h041, 2, 0);
    cyc = 0; #1;
    while (!dhit && cyc < 40) begin tick(); cyc++; #1; end
    chk("miss clean latency", 65'(cyc), 65'(9));
    chk("miss clean xfers", 65'(log_q.size() - base), 65'(2));
    if (log_q.size() >= base + 2) begin
      chk("miss clean rd0", 65'(log_q[base]),   65'({1'b0, 32'h0000_1050, 32'hA5A5_1050}));
      chk("miss clean rd1", 65'(log_q[base+1]), 65'({1'b0, 32'h0000_1054, 32'hA5A5_1054}));
    end
    chk("miss clean fills", 65'(fill_cnt - fb), 65'(2));
    chk("miss clean word1", 65'(m_data[2][0][1]), 65'(32'hA5A5_1054));
    tick();
    dmemREN = 1'b0;
    tick();

    // dirty-victim miss in set 4, way 1 holds tag 0x5
    preload(4, 1, 1, 1, 26'h5, 32'hD0D0_0000, 32'hD1D1_1111);
    m_lru[4] = 1'b1;
    base = log_q.size(); fb = fill_cnt; cb = clean_cnt;
    dmemWEN = 1'b1; dmemaddr = mkaddr(26'h9, 4, 1);
    cyc = 0; #1;
    while (!dhit && cyc < 60) begin tick(); cyc++; #1; end
    chk("miss dirty latency", 65'(cyc), 65'(17));
    ex[0] = {1'b1, mkaddr(26'h5, 4, 0), 32'hD0D0_0000};
    ex[1] = {1'b1, mkaddr(26'h5, 4, 1), 32'hD1D1_1111};
    ex[2] = {1'b0, mkaddr(26'h9, 4, 0), mkaddr(26'h9, 4, 0) ^ 32'hA5A5_0000};
    ex[3] = {1'b0, mkaddr(26'h9, 4, 1), mkaddr(26'h9, 4, 1) ^ 32'hA5A5_0000};
    chk("miss dirty xfers", 65'(log_q.size() - base), 65'(4));
    for (int i = 0; i < 4; i++)
      if (log_q.size() > base + i)
        chk($sformatf("miss dirty xfer%0d", i), 65'(log_q[base+i]), 65'(ex[i]));
    chk("miss dirty clean_wen", 65'(clean_cnt - cb), 65'(1));
    chk("miss dirty fills", 65'(fill_cnt - fb), 65'(2));
    chk("miss dirty new tag", 65'({m_valid[4][1], m_dirty[4][1], m_tag[4][1]}),
        65'({1'b1, 1'b0, 26'h9}));
    tick();
    dmemWEN = 1'b0;
    tick();

    // flush with sets 1w0 and 7w1 dirty
    preload(1, 0, 1, 1, 26'h0AB, 32'hAA00_0000, 32'hAA00_0001);
    preload(7, 1, 1, 1, 26'h77, 32'hEE00_0000, 32'hEE00_0001);
    base = log_q.size();
    halt = 1'b1;
    wait_flushed("flush", 200);
    ex[0] = {1'b1, mkaddr(26'h0AB, 1, 0), 32'hAA00_0000};
    ex[1] = {1'b1, mkaddr(26'h0AB, 1, 1), 32'hAA00_0001};
    ex[2] = {1'b1, mkaddr(26'h77, 7, 0), 32'hEE00_0000};
    ex[3] = {1'b1, mkaddr(26'h77, 7, 1), 32'hEE00_0001};
    ex[4] = {1'b1, 32'h0000_3100, 32'(exp_hits)};
    chk("flush xfers", 65'(log_q.size() - base), 65'(5));
    for (int i = 0; i < 5; i++)
      if (log_q.size() > base + i)
        chk($sformatf("flush xfer%0d", i), 65'(log_q[base+i]), 65'(ex[i]));
    chk("flush cleaned", 65'({m_dirty[1][0], m_dirty[7][1]}), 65'(0));
    halt = 1'b0; dmemREN = 1'b1; dmemaddr = mkaddr(26'h123, 3, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("done sticky%0d", i), 65'({flushed, dhit, dREN, dWEN}), 65'(4'b1000));
      tick();
    end
    dmemREN = 1'b0;

    // halt raised while the fill is in flight
    do_reset();
    clear_model();
    m_lru[6] = 1'b1;
    base = log_q.size(); fb = fill_cnt; db = dhit_cnt;
    dmemREN = 1'b1; dmemaddr = mkaddr(26'h222, 6, 0);
    tick();
    #1;
    chk("halt-in-LD0 dREN", 65'(dREN), 65'(1));
    halt = 1'b1;
    wait_flushed("halt-in-LD", 100);
    ex[0] = {1'b0, mkaddr(26'h222, 6, 0), mkaddr(26'h222, 6, 0) ^ 32'hA5A5_0000};
    ex[1] = {1'b0, mkaddr(26'h222, 6, 1), mkaddr(26'h222, 6, 1) ^ 32'hA5A5_0000};
    ex[2] = {1'b1, 32'h0000_3100, 32'h0};
    chk("halt-in-LD xfers", 65'(log_q.size() - base), 65'(3));
    for (int i = 0; i < 3; i++)
      if (log_q.size() > base + i)
        chk($sformatf("halt-in-LD xfer%0d", i), 65'(log_q[base+i]), 65'(ex[i]));
    chk("halt-in-LD fills", 65'(fill_cnt - fb), 65'(2));
    chk("halt-in-LD no dhit", 65'(dhit_cnt - db), 65'(0));

    // reset in the middle of a stalled writeback
    do_reset();
    clear_model();
    preload(0, 0, 1, 0, 26'h1, 32'h0, 32'h0);
    preload(5, 0, 1, 1, 26'h3, 32'hF000_0000, 32'hF000_0001);
    dmemREN = 1'b1; dmemaddr = mkaddr(26'h1, 0, 0);
    tick(); tick();
    dmemaddr = mkaddr(26'h8, 5, 0);
    base = log_q.size(); cb = clean_cnt;
    cyc = 0;
    while (log_q.size() == base && cyc < 40) begin tick(); cyc++; end
    hold_wait = 1'b1;
    tick();
    #1;
    chk("rst-mid WB1 dWEN", 65'({dWEN, daddr}), 65'({1'b1, mkaddr(26'h3, 5, 1)}));
    RST = 1'b1;
    tick();
    RST = 1'b0; dmemREN = 1'b0; hold_wait = 1'b0;
    #1;
    chk("rst-mid mem idle", 65'({dREN, dWEN, flushed}), 65'(0));
    chk("rst-mid no clean", 65'(clean_cnt - cb), 65'(0));
    chk("rst-mid dirty kept", 65'(m_dirty[5][0]), 65'(1));
    base = log_q.size();
    halt = 1'b1;
    wait_flushed("rst-mid", 200);
    chk("rst-mid flush xfers", 65'(log_q.size() - base), 65'(3));
    if (log_q.size() > 0)
      chk("rst-mid hitcnt store", 65'(log_q[log_q.size()-1]), 65'({1'b1, 32'h0000_3100, 32'h0}));
    halt = 1'b0;

    chk("dREN/dWEN exclusive", 65'(both_cnt), 65'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
